// File: rtl/gptp_pkg.sv
// Shared gPTP timestamp types and constants.
// Used by the tagger, the timestamp adder and the send/receive bridges.
package gptp_pkg;

  localparam int unsigned GPTP_TS_W  = 80;
  localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

  // Bit layout {epoch, sec, ns}, matching the 80-bit wire format.
  typedef struct packed {
    logic [15:0] epoch;
    logic [31:0] sec;
    logic [31:0] ns;
  } gptp_ts_t;

endpackage

// File: rtl/gptp_ts_add.sv
// Combinational timestamp correction: i_ts + i_offset_ns.
// Nanoseconds carry into seconds at 1e9.
// Seconds carry into the epoch when they wrap.
// The epoch wraps silently.
// The inputs must satisfy i_ts.ns < 1e9 and i_offset_ns < 1e9.
// Ports:
//   i_ts        raw timestamp
//   i_offset_ns nanosecond correction
//   o_ts        corrected timestamp
module gptp_ts_add
  import gptp_pkg::*;
(
  input  gptp_ts_t    i_ts,
  input  logic [31:0] i_offset_ns,
  output gptp_ts_t    o_ts
);

  logic [32:0] w_ns_sum;
  logic [32:0] w_sec_sum;
  logic        w_ns_carry;

  always_comb begin
    w_ns_sum   = {1'b0, i_ts.ns} + {1'b0, i_offset_ns};
    w_ns_carry = (w_ns_sum >= {1'b0, NS_PER_SEC});
    w_sec_sum  = {1'b0, i_ts.sec} + {32'd0, w_ns_carry};
    o_ts       = '0;
    // Both operands are below 1e9, so at most one subtraction is ever needed.
    o_ts.ns    = w_ns_carry ? 32'(w_ns_sum - {1'b0, NS_PER_SEC}) : w_ns_sum[31:0];
    o_ts.sec   = w_sec_sum[31:0];
    o_ts.epoch = i_ts.epoch + {15'd0, w_sec_sum[32]};
  end

endmodule

// File: rtl/gptp_ts_tagger.sv
// gPTP timestamp tagger and buffer.
// A frame is accepted on the in handshake, and the RTC is sampled in the same cycle.
// The frame and raw timestamp are staged for one cycle.
// The corrected timestamp is then written back to the sender as a one-cycle pulse.
// The pair {frame, timestamp} is pushed into a DEPTH-entry FIFO.
// Ports:
//   clk, reset (async, active-low)
//   gptp_in_valid/ready/data          sender handshake and frame
//   gptp_ts_wb_valid/data             corrected-timestamp write-back
//   gptp_out_valid/ready/data         FIFO head {frame, epoch, sec, ns}
//   rtc_nanosec/sec/epoch_field       local RTC
//   fifo_level                        FIFO entries, not counting the stage
module gptp_ts_tagger
  import gptp_pkg::*;
#(
  parameter int unsigned FRAME_W      = 352,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned TS_OFFSET_NS = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         gptp_in_valid,
  output logic                         gptp_in_ready,
  input  logic [FRAME_W-1:0]           gptp_in_data,
  output logic                         gptp_ts_wb_valid,
  output logic [79:0]                  gptp_ts_wb_data,
  output logic                         gptp_out_valid,
  input  logic                         gptp_out_ready,
  output logic [FRAME_W+79:0]          gptp_out_data,
  input  logic [31:0]                  rtc_nanosec_field,
  input  logic [31:0]                  rtc_sec_field,
  input  logic [15:0]                  rtc_epoch_field,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LVL_W   = $clog2(DEPTH+1);
  localparam int unsigned ENTRY_W = FRAME_W + GPTP_TS_W;

  logic                 r_stage_valid;
  logic [FRAME_W-1:0]   r_stage_frame;
  gptp_ts_t             r_stage_ts;
  logic [ENTRY_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]     r_level;
  logic                 r_wb_valid;
  gptp_ts_t             r_wb_data;

  gptp_ts_t             w_corr_ts;
  logic [LVL_W:0]       w_occupancy;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;

  gptp_ts_add u_ts_add (
    .i_ts        (r_stage_ts),
    .i_offset_ns (32'(TS_OFFSET_NS)),
    .o_ts        (w_corr_ts)
  );

  // The stage is counted as occupancy, so a push can never find the FIFO full.
  // Ready is gated by reset so that it is low while the block is held in reset.
  assign w_occupancy   = {1'b0, r_level} + (LVL_W+1)'(r_stage_valid);
  assign gptp_in_ready = reset & (w_occupancy < (LVL_W+1)'(DEPTH));
  assign w_accept      = gptp_in_valid & gptp_in_ready;
  assign w_push        = r_stage_valid;
  assign w_pop         = (r_level != '0) & gptp_out_ready;

  assign gptp_out_valid   = (r_level != '0);
  assign gptp_out_data    = r_mem[r_rd_ptr];
  assign fifo_level       = r_level;
  assign gptp_ts_wb_valid = r_wb_valid;
  assign gptp_ts_wb_data  = r_wb_data;

  // Payload registers are not reset; their valid flags qualify them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_stage_frame    <= gptp_in_data;
      r_stage_ts.epoch <= rtc_epoch_field;
      r_stage_ts.sec   <= rtc_sec_field;
      r_stage_ts.ns    <= rtc_nanosec_field;
    end
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_stage_frame, w_corr_ts};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stage_valid <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_data     <= '0;
    end else begin
      r_stage_valid <= w_accept;
      r_wb_valid    <= w_push;
      if (w_push) begin
        r_wb_data <= w_corr_ts;
        r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: tb/tb_gptp_ts_tagger.sv
module tb_gptp_ts_tagger;

  localparam int unsigned FW = 352;
  localparam int unsigned OW = FW + 80;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          gptp_in_valid;
  logic [FW-1:0] gptp_in_data;
  logic          gptp_out_ready;
  logic [31:0]   rtc_ns;
  logic [31:0]   rtc_sec;
  logic [15:0]   rtc_ep;

  // u0: offset 0, u1: offset 100, u2: offset 10 (same stimulus)
  logic          in_ready0, in_ready1, in_ready2;
  logic          wb_valid0, wb_valid1, wb_valid2;
  logic [79:0]   wb_data0,  wb_data1,  wb_data2;
  logic          out_valid0, out_valid1, out_valid2;
  logic [OW-1:0] out_data0, out_data1, out_data2;
  logic [2:0]    level0, level1, level2;

  gptp_ts_tagger #(.FRAME_W(FW), .DEPTH(4), .TS_OFFSET_NS(0)) u0 (
    .clk(clk), .reset(reset),
    .gptp_in_valid(gptp_in_valid), .gptp_in_ready(in_ready0), .gptp_in_data(gptp_in_data),
    .gptp_ts_wb_valid(wb_valid0), .gptp_ts_wb_data(wb_data0),
    .gptp_out_valid(out_valid0), .gptp_out_ready(gptp_out_ready), .gptp_out_data(out_data0),
    .rtc_nanosec_field(rtc_ns), .rtc_sec_field(rtc_sec), .rtc_epoch_field(rtc_ep),
    .fifo_level(level0));

  gptp_ts_tagger #(.FRAME_W(FW), .DEPTH(4), .TS_OFFSET_NS(100)) u1 (
    .clk(clk), .reset(reset),
    .gptp_in_valid(gptp_in_valid), .gptp_in_ready(in_ready1), .gptp_in_data(gptp_in_data),
    .gptp_ts_wb_valid(wb_valid1), .gptp_ts_wb_data(wb_data1),
    .gptp_out_valid(out_valid1), .gptp_out_ready(gptp_out_ready), .gptp_out_data(out_data1),
    .rtc_nanosec_field(rtc_ns), .rtc_sec_field(rtc_sec), .rtc_epoch_field(rtc_ep),
    .fifo_level(level1));

  gptp_ts_tagger #(.FRAME_W(FW), .DEPTH(4), .TS_OFFSET_NS(10)) u2 (
    .clk(clk), .reset(reset),
    .gptp_in_valid(gptp_in_valid), .gptp_in_ready(in_ready2), .gptp_in_data(gptp_in_data),
    .gptp_ts_wb_valid(wb_valid2), .gptp_ts_wb_data(wb_data2),
    .gptp_out_valid(out_valid2), .gptp_out_ready(gptp_out_ready), .gptp_out_data(out_data2),
    .rtc_nanosec_field(rtc_ns), .rtc_sec_field(rtc_sec), .rtc_epoch_field(rtc_ep),
    .fifo_level(level2));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] mk_ts(input logic [15:0] ep, input logic [31:0] s,
                                        input logic [31:0] ns);
    return {ep, s, ns};
  endfunction

  function automatic logic [FW-1:0] frm(input int k);
    return FW'(32'hC0DE_0000 + 32'(k));
  endfunction

  // Handshake one frame and advance to the write-back cycle (two edges).
  task automatic send_one(input logic [FW-1:0] f, input logic [15:0] ep,
                          input logic [31:0] s, input logic [31:0] ns);
    gptp_in_valid = 1'b1;
    gptp_in_data  = f;
    rtc_ep = ep; rtc_sec = s; rtc_ns = ns;
    step();
    gptp_in_valid = 1'b0;
    step();
  endtask

  task automatic pop_one();
    gptp_out_ready = 1'b1;
    step();
    gptp_out_ready = 1'b0;
  endtask

  logic [FW-1:0] fa5;
  logic [FW-1:0] fx;
  int n, rx;
  logic acc;

  initial begin
    fa5 = {44{8'hA5}};
    fx  = {11{32'h5A5A_1234}};
    reset = 1'b1;
    gptp_in_valid = 1'b0; gptp_in_data = '0; gptp_out_ready = 1'b0;
    rtc_ns = '0; rtc_sec = '0; rtc_ep = '0;
    #3 reset = 1'b0;
    step(); step();

    // Reset state
    chk("rst_in_ready", 512'(in_ready0), 512'(0));
    chk("rst_out_valid", 512'(out_valid0), 512'(0));
    chk("rst_wb_valid", 512'(wb_valid0), 512'(0));
    chk("rst_wb_data", 512'(wb_data0), 512'(0));
    chk("rst_level", 512'(level0), 512'(0));
    reset = 1'b1;
    #1;
    chk("rel_in_ready", 512'(in_ready0), 512'(1));

    // Basic transfer; also checks the non-wrapping correction on u1/u2
    gptp_in_valid = 1'b1; gptp_in_data = fa5;
    rtc_ep = 16'd1; rtc_sec = 32'd10; rtc_ns = 32'd500;
    step();
    gptp_in_valid = 1'b0;
    chk("basic_wb_early", 512'(wb_valid0), 512'(0));
    step();
    chk("basic_wb_valid", 512'(wb_valid0), 512'(1));
    chk("basic_wb_data", 512'(wb_data0), 512'(mk_ts(1, 10, 500)));
    chk("basic_out_valid", 512'(out_valid0), 512'(1));
    chk("basic_level", 512'(level0), 512'(1));
    chk("basic_out_data", 512'(out_data0), 512'({fa5, mk_ts(1, 10, 500)}));
    chk("basic_u1_wb", 512'(wb_data1), 512'(mk_ts(1, 10, 600)));
    chk("basic_u1_out", 512'(out_data1), 512'({fa5, mk_ts(1, 10, 600)}));
    chk("basic_u2_wb", 512'(wb_data2), 512'(mk_ts(1, 10, 510)));
    chk("basic_u2_out", 512'(out_data2), 512'({fa5, mk_ts(1, 10, 510)}));
    chk("basic_aux_flags", 512'({wb_valid1, wb_valid2, out_valid1, out_valid2, in_ready1, in_ready2}),
        512'(6'b111111));
    chk("basic_aux_level", 512'({level1, level2}), 512'({3'd1, 3'd1}));
    step();
    chk("basic_wb_pulse_end", 512'(wb_valid0), 512'(0));
    chk("basic_wb_hold", 512'(wb_data0), 512'(mk_ts(1, 10, 500)));
    pop_one();
    chk("basic_pop_level", 512'(level0), 512'(0));
    chk("basic_pop_valid", 512'(out_valid0), 512'(0));

    // Nanosecond wrap
    send_one(frm(1), 16'd2, 32'd7, 32'd999_999_950);
    chk("nswrap_u0", 512'(wb_data0), 512'(mk_ts(2, 7, 999_999_950)));
    chk("nswrap_u1", 512'(wb_data1), 512'(mk_ts(2, 8, 50)));
    chk("nswrap_u2", 512'(wb_data2), 512'(mk_ts(2, 7, 999_999_960)));
    chk("nswrap_u1_out", 512'(out_data1), 512'({frm(1), mk_ts(2, 8, 50)}));
    pop_one();

    // Seconds wrap into epoch
    send_one(frm(2), 16'h0003, 32'hFFFF_FFFF, 32'd999_999_995);
    chk("secwrap_u2", 512'(wb_data2), 512'(mk_ts(16'h0004, 0, 5)));
    chk("secwrap_u1", 512'(wb_data1), 512'(mk_ts(16'h0004, 0, 95)));
    chk("secwrap_u0", 512'(wb_data0), 512'(mk_ts(16'h0003, 32'hFFFF_FFFF, 999_999_995)));
    pop_one();

    // Epoch wrap
    send_one(frm(3), 16'hFFFF, 32'hFFFF_FFFF, 32'd999_999_999);
    chk("epwrap_u2", 512'(wb_data2), 512'(mk_ts(0, 0, 9)));
    chk("epwrap_u1", 512'(wb_data1), 512'(mk_ts(0, 0, 99)));
    pop_one();
    chk("epwrap_level", 512'(level0), 512'(0));

    // Backpressure: six frames offered while the consumer stalls
    rtc_ep = 0; rtc_sec = 0; rtc_ns = 0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      gptp_in_valid = 1'b1;
      gptp_in_data  = frm(16 + n);
      acc = in_ready0;
      step();
      if (acc) n++;
    end
    chk("bp_accepted", 512'(n), 512'(4));
    chk("bp_in_ready", 512'(in_ready0), 512'(0));
    chk("bp_level", 512'(level0), 512'(4));
    gptp_out_ready = 1'b1;
    rx = 0;
    for (int c = 0; c < 20 && rx < 6; c++) begin
      gptp_in_valid = (n < 6);
      gptp_in_data  = frm(16 + n);
      acc = gptp_in_valid & in_ready0;
      if (out_valid0) begin
        chk("bp_order", 512'(out_data0[OW-1:80]), 512'(frm(16 + rx)));
        rx++;
      end
      step();
      if (acc) n++;
    end
    gptp_in_valid = 1'b0;
    gptp_out_ready = 1'b0;
    chk("bp_rx_count", 512'(rx), 512'(6));
    chk("bp_tx_count", 512'(n), 512'(6));
    chk("bp_drained", 512'(level0), 512'(0));

    // Streaming with simultaneous push and pop
    gptp_out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk("st_in_ready", 512'(in_ready0), 512'(1));
      gptp_in_valid = 1'b1;
      gptp_in_data  = frm(32 + k);
      rtc_ns = 32'(k);
      step();
      if (k >= 1) begin
        chk("st_level", 512'(level0), 512'(1));
        chk("st_wb_valid", 512'(wb_valid0), 512'(1));
        chk("st_wb_data", 512'(wb_data0), 512'(mk_ts(0, 0, 32'(k - 1))));
        chk("st_out_frame", 512'(out_data0[OW-1:80]), 512'(frm(32 + k - 1)));
      end
    end
    gptp_in_valid = 1'b0;
    step(); step(); step();
    gptp_out_ready = 1'b0;
    chk("st_drained_level", 512'(level0), 512'(0));
    chk("st_drained_valid", 512'(out_valid0), 512'(0));

    // Reset with three stored entries and one in the stage
    for (int k = 0; k < 4; k++) begin
      gptp_in_valid = 1'b1;
      gptp_in_data  = frm(64 + k);
      step();
    end
    gptp_in_valid = 1'b0;
    chk("mr_pre_level", 512'(level0), 512'(3));
    chk("mr_pre_ready", 512'(in_ready0), 512'(0));
    reset = 1'b0;
    #1;
    chk("mr_out_valid", 512'(out_valid0), 512'(0));
    chk("mr_level", 512'(level0), 512'(0));
    chk("mr_in_ready", 512'(in_ready0), 512'(0));
    chk("mr_wb_valid", 512'(wb_valid0), 512'(0));
    chk("mr_wb_data", 512'(wb_data0), 512'(0));
    step();
    chk("mr_wb_after_edge", 512'(wb_valid0), 512'(0));
    chk("mr_out_after_edge", 512'(out_valid0), 512'(0));
    reset = 1'b1;
    #1;
    chk("mr_rel_ready", 512'(in_ready0), 512'(1));
    send_one(fx, 16'd9, 32'd9, 32'd9);
    chk("mr_new_valid", 512'(out_valid0), 512'(1));
    chk("mr_new_level", 512'(level0), 512'(1));
    chk("mr_new_data", 512'(out_data0), 512'({fx, mk_ts(9, 9, 9)}));
    chk("mr_new_wb", 512'(wb_data0), 512'(mk_ts(9, 9, 9)));
    pop_one();
    chk("mr_no_stale_level", 512'(level0), 512'(0));
    chk("mr_no_stale_valid", 512'(out_valid0), 512'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
